iccm: RTL and testbench

Instruction closely-coupled memory: the responder side of the IFU fetch port. It returns one 32-bit instruction word per cycle, with one-cycle read latency, to the instruction fetch unit. A second valid/ready port with byte strobes lets the program loader or debug logic write the array. An optional post-reset zero-fill sequencer clears the array and reports completion, so the top level can hold fetch off with `ifu_stall_i = ~iccm_init_done`.

---
 rtl/iccm_if.sv | 25 ++
 rtl/iccm.sv | 111 +++++++++++
 tb/tb_iccm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/iccm_if.sv
// Fetch read port, loader/debug write port and init status of the ICCM.
// master = IFU/loader side, slave = the memory.
interface iccm_if;
   logic [31:0] iccm_rd_addr;
   logic        iccm_rd_en;
   logic [31:0] iccm_rd_data;
   logic        iccm_wr_valid;
   logic        iccm_wr_ready;
   logic [31:0] iccm_wr_addr;
   logic [31:0] iccm_wr_data;
   logic [3:0]  iccm_wr_strb;
   logic        iccm_init_done;

   modport master (
      output iccm_rd_addr, iccm_rd_en,
      output iccm_wr_valid, iccm_wr_addr, iccm_wr_data, iccm_wr_strb,
      input  iccm_rd_data, iccm_wr_ready, iccm_init_done
   );

   modport slave (
      input  iccm_rd_addr, iccm_rd_en,
      input  iccm_wr_valid, iccm_wr_addr, iccm_wr_data, iccm_wr_strb,
      output iccm_rd_data, iccm_wr_ready, iccm_init_done
   );
endinterface

// File: rtl/iccm.sv
// ICCM: 32-bit instruction memory, one registered read + one byte-strobed write per cycle.
// Latency 1 cycle, write-first on same-word collision; wr_ready follows init_done only.
// Optional post-reset zero-fill under ICCM_ZERO_INIT_EN.
module iccm #(
   parameter  int DEPTH_WORDS = 4096,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input logic   clk,
   input logic   rst_n,
   iccm_if.slave bus
);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] clr_idx;
   logic          clearing;
   logic          init_done;
   logic          wr_fire;
   logic [31:0]   rd_word;
   logic [31:0]   rd_fwd;
   logic [31:0]   rd_data_q;

   // Byte-offset bits and bits above the array size are don't-care: addresses alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.iccm_rd_addr[31:AW+2], bus.iccm_rd_addr[1:0],
                               bus.iccm_wr_addr[31:AW+2], bus.iccm_wr_addr[1:0]};

   assign rd_idx  = bus.iccm_rd_addr[AW+1:2];
   assign wr_idx  = bus.iccm_wr_addr[AW+1:2];
   assign wr_fire = bus.iccm_wr_valid & init_done;

`ifdef ICCM_ZERO_INIT_EN
   typedef enum logic {CLEAR, READY} fill_state_e;

   fill_state_e   state_q;
   fill_state_e   state_d;
   logic [AW-1:0] clr_idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) begin
            clr_idx_q <= clr_idx_q + AW'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == CLEAR && clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
         state_d = READY;
      end
   end

   always_comb begin
      clearing  = (state_q == CLEAR);
      init_done = (state_q == READY);
      clr_idx   = clr_idx_q;
   end
`else
   assign clearing  = 1'b0;
   assign init_done = 1'b1;
   assign clr_idx   = '0;
`endif

   // Array has no reset; the zero-fill (when built) is the only initialisation.
   always_ff @(posedge clk) begin
      if (clearing) begin
         mem[clr_idx] <= '0;
      end else if (wr_fire) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.iccm_wr_strb[b]) begin
               mem[wr_idx][8*b +: 8] <= bus.iccm_wr_data[8*b +: 8];
            end
         end
      end
   end

   assign rd_word = mem[rd_idx];

   // Same-word write on the read edge is merged in so the fetch sees the new bytes.
   always_comb begin
      rd_fwd = rd_word;
      if (wr_fire && (wr_idx == rd_idx)) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.iccm_wr_strb[b]) begin
               rd_fwd[8*b +: 8] = bus.iccm_wr_data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (clearing) begin
         rd_data_q <= '0;
      end else if (bus.iccm_rd_en) begin
         rd_data_q <= rd_fwd;
      end
   end

   assign bus.iccm_rd_data   = rd_data_q;
   assign bus.iccm_wr_ready  = init_done;
   assign bus.iccm_init_done = init_done;

endmodule

// File: tb/tb_iccm.sv
// Self-checking bench for iccm (DEPTH_WORDS=16): directed vector table, reset/fill
// sequences and randomized traffic against a word-array reference model.
module tb_iccm;
   localparam int DEPTH = 16;
`ifdef ICCM_ZERO_INIT_EN
   localparam bit ZI = 1'b1;
`else
   localparam bit ZI = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   iccm_if bus();

   iccm #(.DEPTH_WORDS(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_pass = 0;
   int n_total = 0;

   // Reference model: plain word array plus readiness / fill-progress bookkeeping.
   logic [31:0] model [DEPTH];
   logic [31:0] exp_rd = 32'h0;
   bit          model_ready = !ZI;
   int          fill_cnt = 0;

   typedef struct {
      logic        rd_en;
      logic [31:0] rd_addr;
      logic        wr_valid;
      logic [31:0] wr_addr;
      logic [31:0] wr_data;
      logic [3:0]  wr_strb;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   // Drive one cycle's inputs, advance one edge, update the model, settle 1 time unit.
   task automatic cycle(input logic re, input logic [31:0] ra, input logic wv,
                        input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
      int wi;
      int ri;
      logic [31:0] mask;
      bus.iccm_rd_en    = re;
      bus.iccm_rd_addr  = ra;
      bus.iccm_wr_valid = wv;
      bus.iccm_wr_addr  = wa;
      bus.iccm_wr_data  = wd;
      bus.iccm_wr_strb  = ws;
      @(posedge clk);
      if (model_ready) begin
         wi = int'((wa >> 2) % DEPTH);
         ri = int'((ra >> 2) % DEPTH);
         if (wv) begin
            mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
            model[wi] = (model[wi] & ~mask) | (wd & mask);
         end
         if (re) exp_rd = model[ri];
      end else begin
         exp_rd = 32'h0;
         fill_cnt++;
         if (fill_cnt == DEPTH) begin
            model_ready = 1'b1;
            foreach (model[i]) model[i] = 32'h0;
         end
      end
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic assert_reset();
      bus.iccm_rd_en    = 1'b0;
      bus.iccm_wr_valid = 1'b0;
      rst_n = 1'b0;
      exp_rd = 32'h0;
      if (ZI) begin
         model_ready = 1'b0;
         fill_cnt    = 0;
      end
      #1;
   endtask

   task automatic run_fill(input string tag);
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b1, (i % 2 == 1) ? 32'h0 : 32'h3C, 1'b1, 32'h3C, 32'hFFFFFFFF, 4'hF);
         chk({tag, "_rd"}, bus.iccm_rd_data, 32'h0);
         chk({tag, "_done"}, {31'h0, bus.iccm_init_done}, {31'h0, (i == DEPTH)});
         chk({tag, "_wrdy"}, {31'h0, bus.iccm_wr_ready}, {31'h0, (i == DEPTH)});
      end
   endtask

   initial begin
      logic        re;
      logic        wv;
      logic [31:0] ra;
      logic [31:0] wa;

      vecs[0]  = '{1'b0, 32'h00, 1'b1, 32'h08, 32'h00000013, 4'hF, 32'h00000000};
      vecs[1]  = '{1'b1, 32'h08, 1'b0, 32'h00, 32'h00000000, 4'h0, 32'h00000013};
      vecs[2]  = '{1'b0, 32'h08, 1'b0, 32'h00, 32'h00000000, 4'h0, 32'h00000013};
      vecs[3]  = '{1'b0, 32'h10, 1'b0, 32'h00, 32'h00000000, 4'h0, 32'h00000013};
      vecs[4]  = '{1'b0, 32'h00, 1'b1, 32'h10, 32'h11223344, 4'hF, 32'h00000013};
      vecs[5]  = '{1'b0, 32'h00, 1'b1, 32'h10, 32'hAABBCCDD, 4'h5, 32'h00000013};
      vecs[6]  = '{1'b1, 32'h10, 1'b0, 32'h00, 32'h00000000, 4'h0, 32'h11BB33DD};
      vecs[7]  = '{1'b1, 32'h20, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
      vecs[8]  = '{1'b0, 32'h00, 1'b1, 32'h04, 32'h12345678, 4'hF, 32'hDEADBEEF};
      vecs[9]  = '{1'b1, 32'h44, 1'b0, 32'h00, 32'h00000000, 4'h0, 32'h12345678};
      vecs[10] = '{1'b1, 32'hFFFFFF84, 1'b0, 32'h00, 32'h00000000, 4'h0, 32'h12345678};
      vecs[11] = '{1'b1, 32'h04, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 32'h12345678};
      vecs[12] = '{1'b1, 32'h04, 1'b1, 32'h04, 32'h000000AA, 4'h1, 32'h123456AA};
      vecs[13] = '{1'b1, 32'h00, 1'b0, 32'h00, 32'h00000000, 4'h0, 32'h00000000};

      bus.iccm_rd_en    = 1'b0;
      bus.iccm_rd_addr  = 32'h0;
      bus.iccm_wr_valid = 1'b0;
      bus.iccm_wr_addr  = 32'h0;
      bus.iccm_wr_data  = 32'h0;
      bus.iccm_wr_strb  = 4'h0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_rd", bus.iccm_rd_data, 32'h0);
      chk("reset_done", {31'h0, bus.iccm_init_done}, {31'h0, !ZI});
      chk("reset_wrdy", {31'h0, bus.iccm_wr_ready}, {31'h0, !ZI});
      rst_n = 1'b1;

      if (ZI) begin
         run_fill("fill");
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 32'(i * 4), 32'h0, 4'hF);
            chk("init_wrdy", {31'h0, bus.iccm_wr_ready}, 32'h1);
         end
      end
      cycle(1'b1, 32'h3C, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("post_fill_rd", bus.iccm_rd_data, 32'h0);

      for (int v = 0; v < 14; v++) begin
         cycle(vecs[v].rd_en, vecs[v].rd_addr, vecs[v].wr_valid,
               vecs[v].wr_addr, vecs[v].wr_data, vecs[v].wr_strb);
         chk($sformatf("vec%0d", v), bus.iccm_rd_data, vecs[v].exp_rd);
      end

      for (int n = 0; n < 400; n++) begin
         re = 1'($urandom_range(0, 1));
         wv = 1'($urandom_range(0, 1));
         ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
         wa = ($urandom_range(0, 2) == 0) ? ra : $urandom;
         cycle(re, ra, wv, wa, $urandom, 4'($urandom_range(0, 15)));
         chk("rand_rd", bus.iccm_rd_data, exp_rd);
         chk("rand_wrdy", {31'h0, bus.iccm_wr_ready}, 32'h1);
      end

      cycle(1'b0, 32'h0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
      cycle(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("pre_reset_rd", bus.iccm_rd_data, 32'hCAFEF00D);
      assert_reset();
      chk("async_reset_rd", bus.iccm_rd_data, 32'h0);
      chk("async_reset_done", {31'h0, bus.iccm_init_done}, {31'h0, !ZI});
      #1;
      rst_n = 1'b1;

      if (ZI) begin
         repeat (7) idle();
         assert_reset();
         chk("midfill_rd", bus.iccm_rd_data, 32'h0);
         chk("midfill_done", {31'h0, bus.iccm_init_done}, 32'h0);
         #1;
         rst_n = 1'b1;
         run_fill("refill");
      end
      cycle(1'b1, 32'h20, 1'b0, 32'h0, 32'h0, 4'h0);
      chk("post_reset_rd", bus.iccm_rd_data, exp_rd);
      chk("post_reset_val", bus.iccm_rd_data, ZI ? 32'h0 : 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
